bcd_to_bin: RTL
===============

// Module: bcd_to_bin
// PURPOSE
//  Sequential BCD-to-binary converter: the inverse of the Abacus binary-to-BCD path.
//  Takes a packed DIGITS-digit BCD value (e.g. keyed-in decimal operand) and produces
//  its binary value by reverse double-dabble (shift right, per-digit >=8 subtract 3).
//  Sits between decimal operand entry and the arithmetic units (adder/multi/divider).
// PARAMETERS
//  DIGITS  5   number of BCD digits accepted (20-bit input, same width as bcdout)
//  BIN_W   17  binary output width; must satisfy 2**BIN_W > 10**DIGITS-1
// PORTS
//  clk      in   1           system clock; all state on rising edge
//  clr_n    in   1           reset: asynchronous, active-low
//  start    in   1           request conversion; sampled only in IDLE
//  bcd_in   in   4*DIGITS    packed BCD, digit 0 in [3:0]; sampled on accepting edge
//  busy     out  1           high while a conversion is in progress (SHIFT state)
//  done     out  1           one-cycle pulse: bin_out/err valid and newly updated
//  bin_out  out  BIN_W       converted value; held until the next done
//  err      out  1           set with done if any input digit > 9; held until next done
// BEHAVIOUR
//  - Reset (clr_n=0, async): state=IDLE, busy=0, done=0, bin_out=0, err=0, counter=0.
//  - FSM states IDLE, SHIFT, DONE; all outputs registered.
//  - IDLE: start=1 at edge k -> load bcd_sr<=bcd_in, bin_sr<=0, cnt<=0.
//      if any digit of bcd_in > 9 -> DONE (err<=1, bin_out<=0); done high after edge k.
//      else -> SHIFT, busy=1 after edge k.
//  - SHIFT: each edge: {bcd_sr,bin_sr} shifted right 1 bit (bcd_sr LSB -> bin_sr MSB),
//      then every 4-bit digit of the shifted bcd_sr that is >=8 gets 3 subtracted.
//      N=4*DIGITS steps, on edges k+1..k+N. On edge k+N: bin_out<=bin_sr result
//      (low BIN_W bits of the 4*DIGITS-bit value), err<=0, state->DONE, busy<=0.
//  - DONE: done=1 for exactly one cycle; next edge -> IDLE. start ignored in DONE.
//  - Latency: valid conversion done high in the cycle after edge k+N (N=20 default);
//      invalid-digit done high in the cycle after edge k.
//  - start while busy or in DONE: ignored, no queueing; bcd_in changes while busy ignored.
//  - start held high continuously: a new conversion is accepted on the first IDLE edge
//      after each done (back-to-back throughput N+2 cycles).
//  - Upper (4*DIGITS-BIN_W) result bits are always 0 for valid input; no overflow flag.
//  - clr_n asserted mid-conversion: aborts immediately, no done pulse, outputs to reset.
// STRUCTURE
//  - Shared include abacus_defs.vh: FSM state encodings (IDLE/SHIFT/DONE), default
//    DIGITS/BIN_W constants, BCD digit-valid limit (9).
//  - One sub-module bcd_digit_adj: combinational 4-bit digit (>=8 ? d-3 : d),
//    instantiated DIGITS times via generate; FSM, counter, shift registers in top.
//  - Counter width $clog2(4*DIGITS+1); no other storage.
// TESTING
//  1 bcd_in=20'h00255, start pulse -> done exactly 21 cycles after start edge, bin_out=255, err=0.
//  2 bcd_in=20'h99999 -> bin_out=17'h1869F (99999), err=0; 20'h00000 -> bin_out=0.
//  3 bcd_in=20'h0A123 -> done the cycle after the start edge, err=1, bin_out=0, busy never high.
//  4 start 20'h00042, re-assert start with 20'h00777 at cycle 5 -> ignored; bin_out=42,
//    single done; following IDLE start with 20'h00777 -> 777.
//  5 clr_n low at cycle 10 of a conversion -> busy/done/bin_out/err 0 immediately, no done;
//    after release, start 20'h00013 -> bin_out=13.
//  6 Round trip: for every value 0..65535 feed bin_to_decimal's bcdout into bcd_in ->
//    bin_out equals original value, err=0, with start held high (back-to-back N+2 cycles).

Source files
------------

// File: rtl/bcd_to_bin_pkg.sv
// Shared constants, FSM encoding and digit-validity helper for the BCD-to-binary converter.
package bcd_to_bin_pkg;

    localparam int          DIGITS_DEF    = 5;
    localparam int          BIN_W_DEF     = 17;
    localparam logic [3:0]  BCD_DIGIT_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic digit_invalid(input logic [3:0] d);
        return d > BCD_DIGIT_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble digit correction: digits >= 8 get 3 subtracted.
// Combinational, zero latency; no flow control.
module bcd_digit_adj (
    input  logic [3:0] d_in,
    output logic [3:0] d_out
);

    assign d_out = (d_in >= 4'd8) ? (d_in - 4'd3) : d_in;

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter; done pulses 4*DIGITS+1 cycles after accept (1 if a digit is invalid).
// start is only sampled in IDLE; requests while busy or in DONE are dropped, never queued.
module bcd_to_bin
    import bcd_to_bin_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEF,
    parameter int BIN_W  = BIN_W_DEF
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int N     = 4 * DIGITS;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N-1:0]       bcd_sr_q, bcd_sr_d;
    logic [N-1:0]       bin_sr_q, bin_sr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [BIN_W-1:0]   bin_out_q, bin_out_d;
    logic               err_q, err_d;

    logic [N-1:0]       bcd_shift;
    logic [N-1:0]       bcd_adj;
    logic [N-1:0]       bin_shift;
    logic               in_bad;

    // One combined right shift of {bcd_sr, bin_sr}, then per-digit correction.
    assign bcd_shift = {1'b0, bcd_sr_q[N-1:1]};
    assign bin_shift = {bcd_sr_q[0], bin_sr_q[N-1:1]};

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d_in  (bcd_shift[4*g +: 4]),
            .d_out (bcd_adj[4*g +: 4])
        );
    end

    always_comb begin
        in_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            in_bad = in_bad | digit_invalid(bcd_in[4*i +: 4]);
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bcd_sr_d  = bcd_sr_q;
        bin_sr_d  = bin_sr_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bin_out_d = bin_out_q;
        err_d     = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    bcd_sr_d = bcd_in;
                    bin_sr_d = '0;
                    cnt_d    = '0;
                    if (in_bad) begin
                        state_d   = ST_DONE;
                        done_d    = 1'b1;
                        err_d     = 1'b1;
                        bin_out_d = '0;
                    end else begin
                        state_d = ST_SHIFT;
                        busy_d  = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                bcd_sr_d = bcd_adj;
                bin_sr_d = bin_shift;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d   = ST_DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    bin_out_d = bin_shift[BIN_W-1:0];
                    err_d     = 1'b0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bcd_sr_q  <= '0;
            bin_sr_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bin_out_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bcd_sr_q  <= bcd_sr_d;
            bin_sr_q  <= bin_sr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bin_out_q <= bin_out_d;
            err_q     <= err_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bin_out = bin_out_q;
    assign err     = err_q;

endmodule
